// File: rtl/int_ctrl.sv
// Interrupt controller: latches source events into PEND, masks them into hw_int,
// and exposes PEND/MASK/MODE/STATUS/CLAIM in a 32-byte memory-mapped window.
module int_ctrl #(
  parameter int          N_SRC     = 6,
  parameter logic [31:0] BASE_ADDR = 32'h0000_7F20
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_SRC-1:0] src,
  input  logic [31:0]      m_data_addr,
  input  logic [31:0]      m_data_wdata,
  input  logic [3:0]       m_data_byteen,
  output logic [31:0]      rdata,
  output logic [N_SRC-1:0] hw_int,
  output logic             irq
);

  logic [N_SRC-1:0] src_q_reg;
  logic [N_SRC-1:0] pend_reg, pend_next;
  logic [N_SRC-1:0] mask_reg, mask_next;
  logic [N_SRC-1:0] mode_reg, mode_next;
  logic [N_SRC-1:0] edge_det, w1c, claim;
  logic             sel, wr0;
  logic [2:0]       offset;
  logic [2:0]       low_idx;
  logic             unused_bits;

  assign sel    = (m_data_addr[31:5] == BASE_ADDR[31:5]);
  assign offset = m_data_addr[4:2];
  // All defined register bits live in byte lane 0, so lane 0 gates every write.
  assign wr0    = sel & m_data_byteen[0];

  assign unused_bits = ^{m_data_addr[1:0], m_data_byteen[3:1], m_data_wdata[31:N_SRC]};

  assign edge_det = src & ~src_q_reg;
  assign w1c      = (wr0 && offset == 3'd0) ? m_data_wdata[N_SRC-1:0] : '0;

  generate
    for (genvar gi = 0; gi < N_SRC; gi++) begin : g_bit
      // Indices >= N_SRC never match a generated bit, so they are ignored.
      assign claim[gi] = wr0 && (offset == 3'd4) && (m_data_wdata[2:0] == 3'(gi));
      // Edge mode: a new edge beats a same-cycle clear. Level mode follows src.
      assign pend_next[gi] = mode_reg[gi]
                           ? (edge_det[gi] | (pend_reg[gi] & ~(w1c[gi] | claim[gi])))
                           : src[gi];
    end
  endgenerate

  assign mask_next = (wr0 && offset == 3'd1) ? m_data_wdata[N_SRC-1:0] : mask_reg;
  assign mode_next = (wr0 && offset == 3'd2) ? m_data_wdata[N_SRC-1:0] : mode_reg;

  always_ff @(posedge clk) begin
    // Sampled through reset so a line held high does not look like a new edge.
    src_q_reg <= src;
    if (reset) begin
      pend_reg <= '0;
      mask_reg <= '0;
      mode_reg <= '1;
    end else begin
      pend_reg <= pend_next;
      mask_reg <= mask_next;
      mode_reg <= mode_next;
    end
  end

  assign hw_int = pend_reg & mask_reg;
  assign irq    = |hw_int;

  always_comb begin
    low_idx = 3'd0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (hw_int[i]) low_idx = 3'(i);
    end
  end

  always_comb begin
    rdata = 32'd0;
    if (sel) begin
      case (offset)
        3'd0:    rdata = 32'(pend_reg);
        3'd1:    rdata = 32'(mask_reg);
        3'd2:    rdata = 32'(mode_reg);
        3'd3:    rdata = {irq, 28'd0, low_idx};
        default: rdata = 32'd0;
      endcase
    end
  end

endmodule

// File: tb/tb_int_ctrl.sv
// Scoreboard bench for int_ctrl: expected values are queued when stimulus is
// driven and popped/compared once the DUT has produced its response.
module tb_int_ctrl;

  localparam logic [31:0] BASE = 32'h0000_7F20;

  logic        clk = 1'b0;
  logic        reset;
  logic [5:0]  src;
  logic [31:0] m_data_addr;
  logic [31:0] m_data_wdata;
  logic [3:0]  m_data_byteen;
  logic [31:0] rdata;
  logic [5:0]  hw_int;
  logic        irq;

  int checks = 0;
  int failures = 0;
  logic [31:0] exp_q[$];
  logic [31:0] exp, got;

  int_ctrl #(.N_SRC(6), .BASE_ADDR(BASE)) dut (
    .clk(clk), .reset(reset), .src(src),
    .m_data_addr(m_data_addr), .m_data_wdata(m_data_wdata), .m_data_byteen(m_data_byteen),
    .rdata(rdata), .hw_int(hw_int), .irq(irq)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    m_data_addr = a; m_data_wdata = d; m_data_byteen = be;
    tick();
    m_data_byteen = 4'b0000; m_data_addr = 32'd0; m_data_wdata = 32'd0;
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] d);
    m_data_addr = a; m_data_byteen = 4'b0000;
    #1;
    d = rdata;
  endtask

  task automatic test_reset();
    logic [31:0] addrs[8];
    src = 6'b000001; reset = 1'b1;
    m_data_addr = 32'd0; m_data_wdata = 32'd0; m_data_byteen = 4'b0000;
    tick(); tick(); tick();
    reset = 1'b0;
    m_data_addr = BASE;
    for (int c = 0; c < 10; c++) begin
      exp_q.push_back(32'd0);
      tick();
      exp = exp_q.pop_front();
      checks++;
      if (rdata !== exp || hw_int !== 6'd0 || irq !== 1'b0) begin
        failures++;
        $display("FAIL reset_no_spurious cycle %0d: pend=%h hw_int=%b irq=%b, required pend=%h hw_int=0 irq=0",
                 c, rdata, hw_int, irq, exp);
      end
    end
    src = 6'd0;
    for (int o = 0; o < 8; o++) addrs[o] = BASE + 32'(o * 4);
    for (int o = 0; o < 8; o++) begin
      exp_q.push_back(o == 2 ? 32'h3F : 32'h0);
      rd(addrs[o], got);
      exp = exp_q.pop_front();
      checks++;
      if (got !== exp) begin
        failures++;
        $display("FAIL reset_read offset %0d: got %h, required %h", o, got, exp);
      end
    end
  endtask

  task automatic test_edge_w1c();
    wr(BASE + 32'h4, 32'h3F, 4'b0001);
    src = 6'b000100;
    exp_q.push_back(32'h4);
    tick();
    src = 6'd0;
    exp = exp_q.pop_front();
    checks++;
    if (hw_int !== exp[5:0] || irq !== 1'b1) begin
      failures++;
      $display("FAIL edge_latch: hw_int=%b irq=%b, required hw_int=%b irq=1", hw_int, irq, exp[5:0]);
    end
    exp_q.push_back(32'h8000_0002);
    rd(BASE + 32'hC, got);
    exp = exp_q.pop_front();
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL status: got %h, required %h", got, exp);
    end
    exp_q.push_back(32'h0);
    wr(BASE, 32'h4, 4'b0001);
    exp = exp_q.pop_front();
    checks++;
    if ({26'd0, hw_int} !== exp || irq !== 1'b0) begin
      failures++;
      $display("FAIL w1c_clear: hw_int=%b irq=%b, required 0/0", hw_int, irq);
    end
  endtask

  task automatic test_set_clear_priority();
    src = 6'b000001;
    tick();
    src = 6'd0;
    tick();
    src = 6'b000001;
    exp_q.push_back(32'h1);
    wr(BASE, 32'h1, 4'b0001);
    rd(BASE, got);
    exp = exp_q.pop_front();
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL set_beats_clear: pend=%h, required %h", got, exp);
    end
    exp_q.push_back(32'h0);
    wr(BASE + 32'h10, 32'h0, 4'b0001);
    rd(BASE, got);
    exp = exp_q.pop_front();
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL claim0: pend=%h, required %h", got, exp);
    end
    src = 6'd0;
    tick();
    src = 6'b000010;
    tick();
    src = 6'd0;
    exp_q.push_back(32'h2);
    wr(BASE + 32'h10, 32'h6, 4'b0001);
    wr(BASE + 32'h10, 32'h1, 4'b0010);
    rd(BASE, got);
    exp = exp_q.pop_front();
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL claim_ignored: pend=%h, required %h", got, exp);
    end
    exp_q.push_back(32'h0);
    rd(BASE + 32'h10, got);
    exp = exp_q.pop_front();
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL claim_read: got %h, required %h", got, exp);
    end
    exp_q.push_back(32'h0);
    wr(BASE + 32'h10, 32'h1, 4'b0001);
    rd(BASE, got);
    exp = exp_q.pop_front();
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL claim1: pend=%h, required %h", got, exp);
    end
  endtask

  task automatic test_level();
    wr(BASE + 32'h8, 32'h0, 4'b0001);
    src = 6'b001000;
    exp_q.push_back(32'h8);
    tick();
    rd(BASE, got);
    exp = exp_q.pop_front();
    checks++;
    if (got !== exp || irq !== 1'b1) begin
      failures++;
      $display("FAIL level_follow: pend=%h irq=%b, required %h irq=1", got, irq, exp);
    end
    exp_q.push_back(32'h8);
    wr(BASE, 32'h8, 4'b0001);
    rd(BASE, got);
    exp = exp_q.pop_front();
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL level_w1c_ignored: pend=%h, required %h", got, exp);
    end
    src = 6'd0;
    exp_q.push_back(32'h0);
    tick();
    rd(BASE, got);
    exp = exp_q.pop_front();
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL level_drop: pend=%h, required %h", got, exp);
    end
    wr(BASE + 32'h8, 32'h3F, 4'b0001);
  endtask

  task automatic test_mask();
    wr(BASE + 32'h4, 32'h0, 4'b0001);
    src = 6'b000010;
    tick();
    src = 6'd0;
    exp_q.push_back(32'h2);
    rd(BASE, got);
    exp = exp_q.pop_front();
    checks++;
    if (got !== exp || hw_int !== 6'd0 || irq !== 1'b0) begin
      failures++;
      $display("FAIL masked_latch: pend=%h hw_int=%b irq=%b, required %h 0 0", got, hw_int, irq, exp);
    end
    m_data_addr = BASE + 32'h4; m_data_wdata = 32'h2; m_data_byteen = 4'b0001;
    #1;
    exp_q.push_back(32'h0);
    exp = exp_q.pop_front();
    checks++;
    if (rdata !== exp) begin
      failures++;
      $display("FAIL read_pre_write: got %h, required %h", rdata, exp);
    end
    exp_q.push_back(32'h2);
    tick();
    m_data_byteen = 4'b0000;
    exp = exp_q.pop_front();
    checks++;
    if ({26'd0, hw_int} !== exp || irq !== 1'b1) begin
      failures++;
      $display("FAIL unmask: hw_int=%b irq=%b, required %b irq=1", hw_int, irq, exp[5:0]);
    end
    wr(BASE, 32'h2, 4'b0001);
  endtask

  task automatic test_byteen_window();
    exp_q.push_back(32'h2);
    wr(BASE + 32'h4, 32'hFFFF_FFFF, 4'b1110);
    wr(BASE + 32'h20, 32'h3F, 4'b1111);
    wr(BASE + 32'hC, 32'h3F, 4'b0001);
    rd(BASE + 32'h5, got);
    exp = exp_q.pop_front();
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL byteen_mask: mask=%h, required %h", got, exp);
    end
    exp_q.push_back(32'h3F);
    rd(BASE + 32'h8, got);
    exp = exp_q.pop_front();
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL outside_write_mode: mode=%h, required %h", got, exp);
    end
    exp_q.push_back(32'h0);
    rd(BASE + 32'h20, got);
    exp = exp_q.pop_front();
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL outside_read: got %h, required %h", got, exp);
    end
  endtask

  task automatic test_reset_discard();
    src = 6'b000100;
    tick();
    src = 6'b001000;
    reset = 1'b1;
    exp_q.push_back(32'h0);
    tick();
    reset = 1'b0;
    src = 6'd0;
    rd(BASE, got);
    exp = exp_q.pop_front();
    checks++;
    if (got !== exp || irq !== 1'b0) begin
      failures++;
      $display("FAIL reset_discard: pend=%h irq=%b, required %h irq=0", got, irq, exp);
    end
  endtask

  initial begin
    test_reset();
    test_edge_w1c();
    test_set_clear_priority();
    test_level();
    test_mask();
    test_byteen_window();
    test_reset_discard();
    if (exp_q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL scoreboard_drain: %0d entries left, required 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/int_ctrl.md
Name: int_ctrl

Overview:
- Memory-mapped interrupt controller between the peripheral sources (timers, external interrupt pin) and the CPU's CP0 hardware-interrupt inputs.
- Latches source events into a pending register and applies a per-source mask.
- Drives the masked pending vector to CP0 as hw_int.
- The interrupt handler clears pending bits through byte-enabled stores on the data bus. The block decodes its own 32-byte address window, next to data memory.

Parameters:
- N_SRC, 6, number of interrupt sources (1..8); register bits above N_SRC-1 read 0 and ignore writes.
- BASE_ADDR, 32'h0000_7F20, byte address of the 32-byte register window; must be 32-byte aligned.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- reset  in  1  synchronous, active-high reset.
- src  in  N_SRC  raw interrupt source lines, synchronous to clk.
- m_data_addr  in  32  CPU data-bus byte address.
- m_data_wdata  in  32  CPU store data, already byte-lane aligned.
- m_data_byteen  in  4  store byte enables; nonzero means a write this cycle.
- rdata  out  32  combinational read data for m_data_addr.
- hw_int  out  N_SRC  pend & mask, to CP0.
- irq  out  1  OR-reduction of hw_int.

Behaviour:
- Window decode: sel = (m_data_addr[31:5] == BASE_ADDR[31:5]). Offset = m_data_addr[4:2]; m_data_addr[1:0] is ignored.
- Register map:
  - offset 0 (+0x00) PEND: read; write-1-to-clear.
  - offset 1 (+0x04) MASK: read/write.
  - offset 2 (+0x08) MODE: read/write; 1 = edge, 0 = level.
  - offset 3 (+0x0C) STATUS: read-only. bit31 = irq; bits[2:0] = index of the lowest-numbered set bit of hw_int (0 if none).
  - offset 4 (+0x10) CLAIM: write-only; clears PEND bit m_data_wdata[2:0] when byteen[0] is set. An index ≥ N_SRC is ignored.
  - offsets 5..7, writes to read-only/unmapped registers, and all accesses with sel=0: writes ignored, reads return 0. Reads of CLAIM return 0.
- Byte enables: a write updates only the enabled byte lanes. Only lane 0 carries defined bits (N_SRC ≤ 8), so a write with byteen[0]=0 changes nothing.
- Source sampling: src_q <= src every posedge, including during reset, so a line held high through reset produces no spurious edge. edge = src & ~src_q.
- PEND next state, per bit i < N_SRC:
  - Edge mode (MODE[i]=1), priority order: set if edge[i]; else clear if (W1C to PEND with wdata[i]=1) or (CLAIM of i); else hold. A set and a clear in the same cycle leave the bit set.
  - Level mode (MODE[i]=0): pend[i] <= src[i]. W1C and CLAIM have no effect.
  - A MODE change takes effect in the next cycle's update. Switching to level mode reloads pend from src at the next edge.
- Latency: src rises before posedge k, edge mode → pend=1 and hw_int/irq high immediately after posedge k (if masked in). A MASK write at posedge k affects hw_int after posedge k.
- Reset values (sync, active-high): pend=0, mask=0, mode=all-ones (edge) on bits [N_SRC-1:0]. Therefore hw_int=0, irq=0, STATUS=0, and rdata is 0 unless addressed. A reset asserted mid-operation discards pending events at that posedge.
- Masked-off sources still latch into pend. Unmasking later raises hw_int without a new edge.
- rdata is purely combinational from the current register state. A read in the same cycle as a write returns the pre-write value.

Test Plan:
- Reset with src=6'b000001 held high, then release; keep src high 10 cycles → PEND=0, hw_int=0 throughout (no spurious edge). All reads return 0 except MODE=0x3F.
- MASK=0x3F; pulse src[2] for one cycle before posedge k → hw_int=6'b000100 and irq=1 after posedge k; STATUS=0x8000_0002. Store 0x4 to BASE+0x0 with byteen=4'b0001 → pend[2]=0 and irq=0 after that posedge.
- pend[0] set; in the same cycle, rising src[0] and W1C of bit 0 → pend[0] stays 1. In the following cycle, CLAIM wdata=0 → pend[0]=0.
- MODE=0x00 (level), src[3]=1 → pend[3]=1. W1C of bit 3 ignored. src[3] drops → pend[3]=0 after the next posedge.
- MASK=0x00, pulse src[1] → pend=0x02, hw_int=0. Then MASK=0x02 → hw_int=0x02 after the write posedge.
- Store to BASE+0x4 with byteen=4'b1110 → MASK unchanged. Store to BASE+0x20 → no register change; read at BASE+0x20 returns 0.
